display_scan_arbiter: RTL
=========================

Name: display_scan_arbiter

Overview:
- Sequencing and sharing controller for the 8-digit seven-segment display path.
- Shares the display between three 32-bit requesters: CPU display register, PC, and cycle counter.
- Generates the digit scan, snapshots the winning source once per frame (tear-free), and applies leading-zero blanking.
- Outputs drive the existing anode bus and 4-bit nibble input of the seven-segment decoder.

Parameters:
SCAN_DIV, 5000, clk cycles per digit slot (must be >= 2)
HOLD_FRAMES, 64, minimum full frames an owner keeps the display while others request

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
req  in  3  display requests; bit i = source i wants the display
src0  in  32  source 0 value (CPU display register)
src1  in  32  source 1 value (PC)
src2  in  32  source 2 value (cycle counter)
lz_blank_en  in  1  enable leading-zero blanking
AN  out  8  anode selects, active-low, one-hot-low or all ones
code  out  4  hex nibble for the current digit
blank  out  1  current slot blanked
owner  out  2  current owner index
owner_valid  out  1  1 when in OWN state
frame_tick  out  1  one-cycle pulse at the frame boundary

Behaviour:
- Reset (asynchronous, immediate, also mid-frame) clears:
  - presc=0, num=0, state=IDLE, owner=2, hold_cnt=0, shadow=0, frame_tick=0.
  - Resulting outputs: AN=8'hFF, code=0, blank=1, owner_valid=0.
- Prescaler:
  - presc counts 0..SCAN_DIV-1, then wraps to 0.
  - tick = (presc==SCAN_DIV-1).
- Scan:
  - num (3 bits) increments on tick; wraps 7->0.
  - Boundary = tick && num==7.
  - frame_tick is registered: high for exactly the cycle after the boundary, 0 otherwise.
- States: IDLE, OWN.
  - Arbitration happens only on the boundary cycle; req changes between boundaries are ignored.
- Round-robin search order: owner+1, owner+2, owner (mod 3).
  - First asserted req in that order wins.
  - Reset owner=2, so the first grant after reset favours source 0.
- At the boundary:
  - IDLE, req==0: stay IDLE.
  - IDLE, req!=0: grant RR winner; state=OWN; hold_cnt=0.
  - OWN, req[owner]==0, other req set: grant RR winner; hold_cnt=0.
  - OWN, req==0: state=IDLE; owner unchanged.
  - OWN, req[owner]==1, hold_cnt>=HOLD_FRAMES, another req set: grant RR winner; hold_cnt=0.
  - Otherwise keep owner; hold_cnt increments, saturating at HOLD_FRAMES.
  - Then shadow <= src[new owner], sampled on the boundary cycle. An unchanged owner also reloads, giving a live update per frame.
  - In IDLE, shadow is not loaded.
- Outputs (combinational from registered num, state, shadow):
  - IDLE: AN=FF, blank=1, code=0.
  - OWN: code=shadow[4*num+3:4*num].
  - Slot blanked if lz_blank_en && num>0 && shadow[31:4*num]==0. Digit 0 is never blanked.
  - Blanked slot: AN=FF, blank=1. Otherwise AN=~(8'b1<<num), blank=0.
- Mid-frame source changes are not visible until the next boundary.
- Width rules: hold_cnt is wide enough for HOLD_FRAMES; presc is wide enough for SCAN_DIV-1; no overflow permitted.

Test Plan (SCAN_DIV=4, HOLD_FRAMES=2):
1. Reset behaviour: assert rst for 3 cycles mid-scan -> AN=FF, blank=1, owner_valid=0, frame_tick=0 immediately; after release, first boundary at cycle 31 and frame_tick high at cycle 32.
2. Single owner: req=001, src0=32'h12345678, lz=0 -> after first boundary owner=0, owner_valid=1.
   - Slots read AN=FE/code=8, FD/7, FB/6 ... 7F/1.
   - Each slot lasts 4 cycles.
3. Leading-zero blanking: src0=32'h000000A5, lz=1 -> digit0 code 5, digit1 code A; digits 2..7 AN=FF, blank=1.
   - src0=0 -> only digit0 shows code 0.
   - lz=0 -> all digits shown.
4. Hold and round-robin: req=011 constant -> owner 0 for 3 frames (hold_cnt 0,1,2), then owner 1 for 3 frames, then owner 0 again.
5. Drop and idle: owner 1, req changes to 100 mid-frame -> owner 1 kept until the boundary, then owner=2 and shadow=src2.
   - Then req=000 -> next frame IDLE, AN=FF throughout, owner stays 2.
6. Tear-free update: change src0 from 32'h11111111 to 32'h22222222 at digit 3 -> remaining digits of that frame show 1; the next frame shows 2.

Source files
------------

// File: rtl/display_scan_arbiter_if.sv
// Display arbiter bus: requester inputs and
// seven-segment scan outputs.
interface display_scan_arbiter_if;
  logic [2:0]  req;
  logic [31:0] src0;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        lz_blank_en;
  logic [7:0]  AN;
  logic [3:0]  code;
  logic        blank;
  logic [1:0]  owner;
  logic        owner_valid;
  logic        frame_tick;

  modport master (
    output req, src0, src1, src2, lz_blank_en,
    input  AN, code, blank, owner, owner_valid,
    input  frame_tick
  );

  modport slave (
    input  req, src0, src1, src2, lz_blank_en,
    output AN, code, blank, owner, owner_valid,
    output frame_tick
  );
endinterface

// File: rtl/display_scan_arbiter.sv
// Digit scan plus round-robin display sharing
// with per-frame snapshot and zero blanking.
module display_scan_arbiter #(
  parameter int SCAN_DIV    = 5000,
  parameter int HOLD_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  display_scan_arbiter_if.slave bus
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int HW =
    (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
  localparam logic [PW-1:0] PRESC_MAX =
    PW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX =
    HW'(HOLD_FRAMES);

  typedef enum logic {
    IDLE,
    OWN
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [2:0]      num_q, num_d;
  logic [1:0]      owner_q, owner_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [31:0]     shadow_q, shadow_d;
  logic            ftick_q;

  logic            tick;
  logic            boundary;
  logic [3:0]      req_x;
  logic [2:0]      others;
  logic            req_cur;
  logic [1:0]      winner;
  logic [31:0]     upper;
  logic            slot_blk;

  function automatic logic [1:0] rr_pick(
    input logic [1:0] cur,
    input logic [3:0] r
  );
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = (cur == 2'd2) ? 2'd0 : cur + 2'd1;
    c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    if (r[c1])      return c1;
    else if (r[c2]) return c2;
    else            return cur;
  endfunction

  function automatic logic [31:0] src_sel(
    input logic [1:0]  idx,
    input logic [31:0] s0,
    input logic [31:0] s1,
    input logic [31:0] s2
  );
    unique case (idx)
      2'd0:    return s0;
      2'd1:    return s1;
      default: return s2;
    endcase
  endfunction

  assign tick     = (presc_q == PRESC_MAX);
  assign boundary = tick && (num_q == 3'd7);
  assign req_x    = {1'b0, bus.req};
  assign req_cur  = req_x[owner_q];
  assign others   = bus.req & ~(3'b001 << owner_q);
  assign winner   = rr_pick(owner_q, req_x);

  // State, scan counters and frame snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      num_q    <= '0;
      state_q  <= IDLE;
      owner_q  <= 2'd2;
      hold_q   <= '0;
      shadow_q <= '0;
      ftick_q  <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      num_q    <= num_d;
      state_q  <= state_d;
      owner_q  <= owner_d;
      hold_q   <= hold_d;
      shadow_q <= shadow_d;
      ftick_q  <= boundary;
    end
  end

  // Scan advance; ownership decided only at frame end.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    hold_d   = hold_q;
    shadow_d = shadow_q;
    presc_d  = tick ? '0 : presc_q + 1'b1;
    num_d    = tick ? num_q + 3'd1 : num_q;
    if (boundary) begin
      unique case (state_q)
        IDLE: begin
          if (bus.req != 3'b000) begin
            state_d = OWN;
            owner_d = winner;
            hold_d  = '0;
          end
        end
        OWN: begin
          if (bus.req == 3'b000) begin
            state_d = IDLE;
          end else if ((others != 3'b000) &&
                       (!req_cur ||
                        hold_q >= HOLD_MAX)) begin
            owner_d = winner;
            hold_d  = '0;
          end else if (hold_q < HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (state_d == OWN) begin
        shadow_d = src_sel(owner_d, bus.src0,
                           bus.src1, bus.src2);
      end
    end
  end

  // Digit drive from the frame snapshot.
  always_comb begin
    bus.AN    = 8'hFF;
    bus.code  = 4'h0;
    bus.blank = 1'b1;
    upper     = shadow_q >> {num_q, 2'b00};
    slot_blk  = bus.lz_blank_en &&
                (num_q != 3'd0) &&
                (upper == 32'h0);
    if (state_q == OWN) begin
      bus.code = shadow_q[{num_q, 2'b00} +: 4];
      if (!slot_blk) begin
        bus.AN    = ~(8'b1 << num_q);
        bus.blank = 1'b0;
      end
    end
  end

  assign bus.owner       = owner_q;
  assign bus.owner_valid = (state_q == OWN);
  assign bus.frame_tick  = ftick_q;

endmodule
